// File: rtl/inst_fetch_unit.sv
// ============================================================================
// Module   : inst_fetch_unit
// Brief    : Instruction fetch front end. Issues one-cycle-latency SRAM reads,
//            buffers returned words with their byte addresses in a small FIFO
//            and hands them to the pipeline over a valid/ready handshake.
//            Handles pipeline redirects (flush + new PC) and a delivery quota.
//            Optional stall-cycle counter enabled by macro IFU_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] PC_RESET = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [11:0] num_inst,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    output logic [11:0] imem_addr,
    input  logic [31:0] imem_dout,
    output logic        in_valid,
    input  logic        in_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_addr,
    output logic        busy,
    output logic [15:0] stall_cycles
);

    localparam int                c_aw    = $clog2(DEPTH);
    localparam int                c_cw    = c_aw + 1;
    localparam logic [c_aw:0]     c_depth = c_cw'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [11:0]       num_q, num_d;
    logic [11:0]       issued_q, issued_d;
    logic [c_aw:0]     count_q, count_d;
    logic [c_aw-1:0]   wr_ptr_q, wr_ptr_d;
    logic [c_aw-1:0]   rd_ptr_q, rd_ptr_d;
    logic              inflight_q, inflight_d;
    logic [31:0]       inflight_addr_q, inflight_addr_d;

    logic [31:0]       fifo_inst_q [DEPTH];
    logic [31:0]       fifo_addr_q [DEPTH];

    logic              push;
    logic              pop;
    logic              issue;
    logic              flush;
    logic [c_aw:0]     free_entries;
    logic [11:0]       discarded;

    assign in_valid     = (count_q != '0);
    assign pop          = in_valid && in_ready;
    assign flush        = redirect && (state_q != ST_IDLE);
    assign free_entries = c_depth - count_q;
    // A read is only launched if its data is guaranteed a FIFO slot on return.
    assign issue        = (state_q == ST_FETCH) && !flush && (issued_q != num_q) &&
                          (free_entries > c_cw'(inflight_q));
    assign push         = inflight_q && !flush;
    // Entries thrown away by a redirect; a same-cycle pop is still delivered.
    assign discarded    = 12'(count_q) - 12'(pop) + 12'(inflight_q);

    assign imem_addr = pc_q[13:2];
    assign busy      = (state_q != ST_IDLE);
    assign inst      = in_valid ? fifo_inst_q[rd_ptr_q] : 32'h0;
    assign inst_addr = in_valid ? fifo_addr_q[rd_ptr_q] : 32'h0;

    // Next-state, PC, quota and FIFO pointer computation.
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        num_d           = num_q;
        issued_d        = issued_q;
        count_d         = count_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        inflight_d      = issue;
        inflight_addr_d = issue ? pc_q : inflight_addr_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pc_d     = PC_RESET;
                    num_d    = num_inst;
                    issued_d = 12'd0;
                    state_d  = (num_inst == 12'd0) ? ST_DRAIN : ST_FETCH;
                end
            end
            default: begin
                if (flush) begin
                    count_d  = '0;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    pc_d     = redirect_addr;
                    issued_d = issued_q - discarded;
                    state_d  = (issued_d < num_q) ? ST_FETCH : ST_DRAIN;
                end else begin
                    if (issue) begin
                        pc_d     = pc_q + 32'd4;
                        issued_d = issued_q + 12'd1;
                    end
                    if (push) begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                    if (pop) begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                    end
                    count_d = count_q + c_cw'(push) - c_cw'(pop);
                    if ((state_q == ST_FETCH) && (issued_d == num_q)) begin
                        state_d = ST_DRAIN;
                    end else if ((state_q == ST_DRAIN) && (count_d == '0) && !inflight_d) begin
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            pc_q            <= PC_RESET;
            num_q           <= 12'd0;
            issued_q        <= 12'd0;
            count_q         <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_addr_q <= 32'h0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            num_q           <= num_d;
            issued_q        <= issued_d;
            count_q         <= count_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            inflight_q      <= inflight_d;
            inflight_addr_q <= inflight_addr_d;
        end
    end

    // FIFO storage; contents are masked by in_valid so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_inst_q[wr_ptr_q] <= imem_dout;
            fifo_addr_q[wr_ptr_q] <= inflight_addr_q;
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic [15:0] stall_q, stall_d;

    // Saturating count of cycles where an instruction waits on the pipeline.
    always_comb begin
        stall_d = stall_q;
        if ((state_q == ST_IDLE) && start) begin
            stall_d = 16'h0;
        end else if (in_valid && !in_ready && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= 16'h0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = 16'h0;
`endif

endmodule

`default_nettype wire
